// File: rtl/spi_packet_rx_if.sv
// SPI frame receiver bus: serial inputs plus committed-frame outputs.
// The slave side is the receiver and the master side is the host/testbench.
interface spi_packet_rx_if #(
  parameter int W = 96
);
  logic         cs;
  logic         sck;
  logic         sdi;
  logic [W-1:0] frame_data;
  logic         load;
  logic         frame_err;
  logic         busy;

  modport master (
    output cs, sck, sdi,
    input  frame_data, load, frame_err, busy
  );

  modport slave (
    input  cs, sck, sdi,
    output frame_data, load, frame_err, busy
  );
endinterface

// File: rtl/spi_packet_rx.sv
// SPI slave frame deserialiser feeding the per-track tone generators.
// Whole frames commit atomically; short or long frames are dropped and flagged.
module spi_packet_rx #(
  parameter int NUM_TRACKS  = 4,
  parameter int PACKET_SIZE = 24,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  spi_packet_rx_if.slave bus
);
  localparam int N  = NUM_TRACKS * PACKET_SIZE;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic                   cs_h;
  logic                   sck_h;

  logic          cs_s;
  logic          sck_s;
  logic          sdi_s;
  logic          cs_rise;
  logic          capture;

  state_t        state;
  state_t        state_d;
  logic [N-1:0]  shift_q;
  logic [CW-1:0] cnt;
  logic [N-1:0]  data_q;
  logic          load_q;
  logic          err_q;
  logic          load_d;
  logic          err_d;

  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign sck_s   = sck_q[SYNC_STAGES-1];
  assign sdi_s   = sdi_q[SYNC_STAGES-1];
  assign cs_rise = cs_s & ~cs_h;
  assign capture = sck_s & ~sck_h & cs_s;

  // Synchronisers; sdi shares the sck depth so data stays aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q  <= '0;
      sck_q <= '0;
      sdi_q <= '0;
      cs_h  <= 1'b0;
      sck_h <= 1'b0;
    end else begin
      cs_q  <= {cs_q[SYNC_STAGES-2:0], bus.cs};
      sck_q <= {sck_q[SYNC_STAGES-2:0], bus.sck};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], bus.sdi};
      cs_h  <= cs_s;
      sck_h <= sck_s;
    end
  end

  // Bit capture and saturating bit counter; cs rise restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt     <= '0;
    end else begin
      if (capture)
        shift_q <= {shift_q[N-2:0], sdi_s};
      if (cs_rise)
        cnt <= capture ? CW'(1) : '0;
      else if (capture && cnt != CNT_SAT)
        cnt <= cnt + CW'(1);
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Next state and commit decision on the synced cs fall.
  always_comb begin
    state_d = state;
    load_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_rise)
          state_d = SHIFT;
      end
      SHIFT: begin
        if (!cs_s) begin
          state_d = COMMIT;
          unique case (1'b1)
            (cnt == CNT_FULL): load_d = 1'b1;
            (cnt == '0):       ;
            default:           err_d  = 1'b1;
          endcase
        end
      end
      COMMIT: begin
        state_d = cs_rise ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register and one-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (load_d)
        data_q <= shift_q;
      load_q <= load_d;
      err_q  <= err_d;
    end
  end

  assign bus.frame_data = data_q;
  assign bus.load       = load_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = cs_s;
endmodule

// File: doc/spi_packet_rx.md
Name: spi_packet_rx

Overview:
- SPI slave front end that sits directly upstream of the per-track tone generators in `top`.
- Deserialises one frame of NUM_TRACKS×PACKET_SIZE bits from the host (cs, sck, sdi), MSB first.
- On frame close, commits the whole frame atomically to a holding register and pulses a one-cycle load strobe so all tone generators update together.
- Malformed frames are discarded and flagged; the holding register keeps its previous contents.

Parameters:
- NUM_TRACKS, 4, number of tracks (tone generators) fed.
- PACKET_SIZE, 24, bits per track per frame. Field layout per track: [23:8] tone divider, [7:0] level.
- SYNC_STAGES, 2, synchroniser depth on cs, sck and sdi (minimum 2).

Ports:
- clk  in  1  system clock; sole clock of the block.
- reset  in  1  asynchronous, active-low reset (block resets while reset=0).
- cs  in  1  chip select, active-high; frame spans one cs high interval. Asynchronous to clk.
- sck  in  1  SPI clock; sdi sampled on sck rising edge. Asynchronous to clk.
- sdi  in  1  serial data, MSB of the frame first.
- frame_data  out  NUM_TRACKS*PACKET_SIZE  last committed frame. The first bit received lands in the MSB; track 0 occupies the top PACKET_SIZE bits.
- load  out  1  one-cycle strobe; frame_data changed this cycle.
- frame_err  out  1  one-cycle strobe; a frame was rejected.
- busy  out  1  synchronised cs level (frame in progress).

Behaviour:
- Reset (async, reset=0): all synchroniser flops, shift register, bit counter, frame_data, load, frame_err and busy are 0. Release is synchronous to the next clk edge.
- Synchronisation:
  - cs, sck and sdi each pass through SYNC_STAGES flops, plus one history flop on cs and sck for edge detection.
  - The sdi path has the same depth as the sck path, so data and clock stay aligned.
- Input timing requirements:
  - sck high and low phases ≥ SYNC_STAGES+1 clk periods each.
  - sdi is stable from 1 clk before to SYNC_STAGES+1 clk after each sck rise.
- Bit capture:
  - Occurs when a synced sck rising edge is detected AND synced cs=1.
  - shift ← {shift[N-2:0], sdi_sync}, where N=NUM_TRACKS*PACKET_SIZE.
  - Bit counter (width clog2(N+2)) increments, saturating at N+1.
- States:
  - IDLE: synced cs=0. sck edges are ignored.
  - SHIFT: entered on synced cs rise. Counter clears to 0 on entry; the shift register is not cleared.
  - COMMIT: single cycle, on synced cs fall. Returns to IDLE.
- Commit rules, evaluated on the cs fall:
  - count==N: frame_data ← shift; load=1 for exactly one cycle.
  - count==0: no action; neither strobe asserts.
  - 0<count<N or count>N: frame_data unchanged; frame_err=1 for one cycle.
- Commit latency: if cs falls meeting setup before clk edge E1 (SYNC_STAGES=2), load/frame_err are registered at edge E3. frame_data updates on the same edge as load.
- Simultaneous events:
  - An sck rise detected in the same cycle as the cs fall is ignored, because synced cs is already 0.
  - An sck rise in the same cycle as the cs rise is captured as bit 0.
- cs re-rising immediately after COMMIT starts a new frame normally. Back-to-back frames need synced cs low for ≥1 clk.
- Reset asserted mid-frame: partial frame lost; frame_data returns to 0; no strobe.
- Between loads, frame_data is held stable. Downstream may sample it on any cycle.

Test Plan:
1. NUM_TRACKS=4, 96 bits of 96'h0114ff0217ff0114ff0217ff, then cs low -> frame_data == that value; load high exactly 1 cycle at E3; frame_err stays 0; track 0 slice == 24'h0114ff.
2. Good frame as in (1), then a 50-bit frame of ones -> frame_err pulses once; load stays 0; frame_data unchanged.
3. 97 bits sent -> frame_err pulse; frame_data unchanged. Then 0 bits (cs high 10 clk, no sck) -> no strobe of either kind.
4. Two back-to-back good frames (A, then 96'h00ffff00ffff00ffff00ffff) with cs low 3 clk between -> exactly two load pulses; final frame_data equals the second frame.
5. Assert reset (0) at bit 40 of a frame, release, send a full good frame -> frame_data 0 during reset; a single load follows the full frame; no frame_err.
6. NUM_TRACKS=1, 24'h0217ff -> frame_data == 24'h0217ff; load 1 cycle; busy mirrors synced cs, delayed 2 clk.
